// File: rtl/stepdown_seq_pkg.sv
// rtl/stepdown_seq_pkg.sv - shared state encoding and constants for the gate sequencer
// Purpose: FSM state codes (also exported on state_o) and the dead-time floor.
// Ports: none (package).
package stepdown_seq_pkg;

  // Codes are fixed so state_o reads the same in every build; LS_PARK keeps code 6
  // even when diode emulation is compiled out.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LS      = 3'd1,
    ST_DT_LH   = 3'd2,
    ST_HS      = 3'd3,
    ST_DT_HL   = 3'd4,
    ST_FAULT   = 3'd5,
    ST_LS_PARK = 3'd6
  } seq_state_e;

  // Shortest dead time ever inserted; a zero dt_cfg is raised to this.
  localparam int unsigned DT_MIN = 1;

endpackage

// File: rtl/stepdown_gate_sequencer_if.sv
// rtl/stepdown_gate_sequencer_if.sv - gate-drive request/enable bundle
// Purpose: groups the PWM request, zero-cross sense and the two driver enables.
// Ports: pwm_req, zcd (comparator side -> sequencer); hs_on, ls_on (sequencer -> bricks).
// master = PWM comparator / inverter-brick side, slave = sequencer.
interface stepdown_gate_sequencer_if;
  logic pwm_req;
  logic zcd;
  logic hs_on;
  logic ls_on;

  modport master (output pwm_req, output zcd, input hs_on, input ls_on);
  modport slave  (input pwm_req, input zcd, output hs_on, output ls_on);
endinterface

// File: rtl/stepdown_seq_cnt.sv
// rtl/stepdown_seq_cnt.sv - loadable down-counter with a last-cycle done flag
// Purpose: times dead time and minimum on-time for the sequencer.
// Ports: clk, rst_n (async active-low), load, load_val[W], done.
// done is high while the count is 0 or 1, i.e. during the final cycle of a loaded
// interval, so a caller that leaves its state on done spends exactly load_val cycles
// there (a load of 0 behaves like 1; callers decide what 0 means).
module stepdown_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q[W-1:1] == '0);

endmodule

// File: rtl/stepdown_gate_sequencer.sv
// rtl/stepdown_gate_sequencer.sv - break-before-make HS/LS gate sequencer
// Purpose: turns pwm_req into non-overlapping HS/LS enables with programmable dead
//   time, minimum HS on-time and latched fault shutdown.
// Ports: clk, rst_n (async active-low), en, fault, dt_cfg[DT_W], minon_cfg[MINON_W],
//   gate (slave: pwm_req, zcd in; hs_on, ls_on out), fault_lat, state_o[3].
// Build option: STEPDOWN_SEQ_ZCD_EN enables diode emulation (LS_PARK on zcd in LS);
//   without it zcd is ignored and LS conducts continuously.
module stepdown_gate_sequencer
  import stepdown_seq_pkg::*;
#(
  parameter int DT_W    = 4,
  parameter int MINON_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      fault,
  input  logic [DT_W-1:0]           dt_cfg,
  input  logic [MINON_W-1:0]        minon_cfg,
  stepdown_gate_sequencer_if.slave  gate,
  output logic                      fault_lat,
  output logic [2:0]                state_o
);

  seq_state_e        state_q, state_d;
  logic              hs_q, ls_q, flt_q;
  logic              dt_load, mo_load;
  logic              dt_done, mo_done;
  logic [DT_W-1:0]   dt_eff;

  assign dt_eff = (dt_cfg == '0) ? DT_W'(DT_MIN) : dt_cfg;

  // Configuration is captured only on load, so mid-interval edits wait for the next one.
  stepdown_seq_cnt #(.W(DT_W)) u_dt_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dt_load),
    .load_val (dt_eff),
    .done     (dt_done)
  );

  stepdown_seq_cnt #(.W(MINON_W)) u_minon_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mo_load),
    .load_val (minon_cfg),
    .done     (mo_done)
  );

`ifndef STEPDOWN_SEQ_ZCD_EN
  logic zcd_unused;
  assign zcd_unused = gate.zcd;
`endif

  // Priority: fault, then en=0, then pwm_req (then zcd when diode emulation is built in).
  always_comb begin
    state_d = state_q;
    dt_load = 1'b0;
    mo_load = 1'b0;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_d = ST_LS;
        ST_LS: begin
          if (!en) begin
            state_d = ST_DT_HL;
            dt_load = 1'b1;
          end else if (gate.pwm_req) begin
            state_d = ST_DT_LH;
            dt_load = 1'b1;
          end
`ifdef STEPDOWN_SEQ_ZCD_EN
          else if (gate.zcd) begin
            state_d = ST_LS_PARK;
          end
`endif
        end
        ST_DT_LH: begin
          // Both drivers are already off, so a stop request ends straight in IDLE.
          if (dt_done) begin
            if (!en) begin
              state_d = ST_IDLE;
            end else if (gate.pwm_req) begin
              state_d = ST_HS;
              mo_load = 1'b1;
            end else begin
              state_d = ST_LS;
            end
          end
        end
        ST_HS: begin
          if (mo_done && (!en || !gate.pwm_req)) begin
            state_d = ST_DT_HL;
            dt_load = 1'b1;
          end
        end
        ST_DT_HL: if (dt_done) state_d = en ? ST_LS : ST_IDLE;
        ST_FAULT: if (!en) state_d = ST_IDLE;
`ifdef STEPDOWN_SEQ_ZCD_EN
        ST_LS_PARK: begin
          // LS is already off, so HS may turn on without a dead-time gap.
          if (!en) begin
            state_d = ST_IDLE;
          end else if (gate.pwm_req) begin
            state_d = ST_HS;
            mo_load = 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Enables are registered from the next state so they change on the same edge as state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= (state_d == ST_HS);
      ls_q    <= (state_d == ST_LS);
      flt_q   <= (state_d == ST_FAULT);
    end
  end

  assign gate.hs_on = hs_q;
  assign gate.ls_on = ls_q;
  assign fault_lat  = flt_q;
  assign state_o    = state_q;

  a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n) !(hs_q && ls_q));

endmodule

// File: tb/tb_stepdown_gate_sequencer.sv
// tb/tb_stepdown_gate_sequencer.sv - self-checking bench for stepdown_gate_sequencer
module tb_stepdown_gate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       fault;
  logic [3:0] dt_cfg;
  logic [5:0] minon_cfg;
  logic       fault_lat;
  logic [2:0] state_o;

  stepdown_gate_sequencer_if gif ();

  stepdown_gate_sequencer #(.DT_W(4), .MINON_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fault     (fault),
    .dt_cfg    (dt_cfg),
    .minon_cfg (minon_cfg),
    .gate      (gif),
    .fault_lat (fault_lat),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

`ifdef STEPDOWN_SEQ_ZCD_EN
  localparam bit PARK_ON = 1'b1;
`else
  localparam bit PARK_ON = 1'b0;
`endif

  // Reference: a phase plus the edge index it began on and the interval it must last.
  typedef enum int {P_OFF, P_LOW, P_GAP_UP, P_HIGH, P_GAP_DN, P_TRIP, P_PARK} phase_e;
  typedef struct {
    phase_e ph;
    int     t0;
    int     span;
  } model_t;

  model_t m;
  int     cyc;
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic int code_of(phase_e p);
    case (p)
      P_LOW:    return 1;
      P_GAP_UP: return 2;
      P_HIGH:   return 3;
      P_GAP_DN: return 4;
      P_TRIP:   return 5;
      P_PARK:   return 6;
      default:  return 0;
    endcase
  endfunction

  function automatic model_t mnext(model_t mc, int e, logic en_i, logic flt_i, logic pwm_i,
                                   logic zcd_i, int dt_i, int mo_i);
    model_t n;
    int     gap_len;
    n = mc;
    gap_len = (dt_i < 1) ? 1 : dt_i;
    if (flt_i) begin
      n.ph = P_TRIP;
    end else begin
      case (mc.ph)
        P_OFF: if (en_i) n.ph = P_LOW;
        P_LOW: begin
          if (!en_i || pwm_i) begin
            n.ph = en_i ? P_GAP_UP : P_GAP_DN;
            n.t0 = e;
            n.span = gap_len;
          end else if (zcd_i && PARK_ON) begin
            n.ph = P_PARK;
          end
        end
        P_GAP_UP: begin
          if (e - mc.t0 >= mc.span) begin
            if (!en_i) n.ph = P_OFF;
            else if (pwm_i) begin
              n.ph = P_HIGH;
              n.t0 = e;
              n.span = mo_i;
            end else n.ph = P_LOW;
          end
        end
        P_HIGH: begin
          if ((!en_i || !pwm_i) && (e - mc.t0 >= ((mc.span < 1) ? 1 : mc.span))) begin
            n.ph = P_GAP_DN;
            n.t0 = e;
            n.span = gap_len;
          end
        end
        P_GAP_DN: if (e - mc.t0 >= mc.span) n.ph = en_i ? P_LOW : P_OFF;
        P_TRIP:   if (!en_i) n.ph = P_OFF;
        P_PARK: begin
          if (!en_i) n.ph = P_OFF;
          else if (pwm_i) begin
            n.ph = P_HIGH;
            n.t0 = e;
            n.span = mo_i;
          end
        end
        default: n.ph = P_OFF;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '{P_OFF, 0, 0};
      cyc <= 0;
    end else begin
      m   <= mnext(m, cyc + 1, en, fault, gif.pwm_req, gif.zcd, int'(dt_cfg), int'(minon_cfg));
      cyc <= cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_eq("hs_on", gif.hs_on, (m.ph == P_HIGH));
    check_eq("ls_on", gif.ls_on, (m.ph == P_LOW));
    check_eq("fault_lat", fault_lat, (m.ph == P_TRIP));
    check_eq("state_o", state_o, code_of(m.ph));
    check_eq("no_overlap", gif.hs_on & gif.ls_on, 0);
  endtask

  task automatic goto_ls();
    en = 1'b1;
    fault = 1'b0;
    gif.pwm_req = 1'b0;
    gif.zcd = 1'b0;
    for (int i = 0; i < 40 && state_o != 3'd1; i++) tick();
    check_eq("goto_ls", state_o, 1);
  endtask

  initial begin
    int n, hi, gap, ngaps, run;
    logic ever_hs;

    rst_n = 1'b0;
    en = 1'b0;
    fault = 1'b0;
    gif.pwm_req = 1'b0;
    gif.zcd = 1'b0;
    dt_cfg = 4'd0;
    minon_cfg = 6'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_hs", gif.hs_on, 0);
    check_eq("rst_ls", gif.ls_on, 0);
    check_eq("rst_fault_lat", fault_lat, 0);
    check_eq("rst_state", state_o, 0);
    rst_n = 1'b1;
    tick();

    // Basic dead time: dt=3 -> LS drops next cycle, HS four cycles after the edge.
    dt_cfg = 4'd3;
    minon_cfg = 6'd0;
    goto_ls();
    gif.pwm_req = 1'b1;
    tick();
    check_eq("dt_ls_fall", gif.ls_on, 0);
    n = 1;
    while (!gif.hs_on && n < 20) begin
      tick();
      n++;
    end
    check_eq("dt_hs_latency", n, 4);

    // dt=0 acts as 1: every handover leaves exactly one dead cycle.
    dt_cfg = 4'd0;
    gap = 0;
    ngaps = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) gif.pwm_req = ~gif.pwm_req;
      tick();
      if (!gif.hs_on && !gif.ls_on) gap++;
      else begin
        if (gap != 0) begin
          check_eq("dt0_gap", gap, 1);
          ngaps++;
        end
        gap = 0;
      end
    end
    check_eq("dt0_gap_count", ngaps, 6);

    // Minimum on-time of 8 holds HS past a 2-cycle request.
    dt_cfg = 4'd1;
    goto_ls();
    minon_cfg = 6'd8;
    gif.pwm_req = 1'b1;
    tick();
    tick();
    gif.pwm_req = 1'b0;
    hi = 0;
    for (int i = 0; i < 40 && gif.hs_on; i++) begin
      hi++;
      tick();
    end
    check_eq("minon_len", hi, 8);
    check_eq("minon_then_dthl", state_o, 4);
    tick();
    check_eq("minon_then_ls", state_o, 1);

    // One-cycle request with dt=5 aborts back to LS without HS.
    dt_cfg = 4'd5;
    gif.pwm_req = 1'b1;
    tick();
    check_eq("glitch_dtlh", state_o, 2);
    gif.pwm_req = 1'b0;
    ever_hs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ever_hs |= gif.hs_on;
    end
    check_eq("glitch_no_hs", ever_hs, 0);
    check_eq("glitch_back_ls", state_o, 1);

    // Fault during min-on, then the en=0 handshake out of FAULT.
    dt_cfg = 4'd1;
    minon_cfg = 6'd20;
    gif.pwm_req = 1'b1;
    for (int i = 0; i < 20 && !gif.hs_on; i++) tick();
    check_eq("fault_reach_hs", gif.hs_on, 1);
    tick();
    tick();
    fault = 1'b1;
    tick();
    check_eq("fault_hs_off", gif.hs_on, 0);
    check_eq("fault_latched", fault_lat, 1);
    check_eq("fault_state", state_o, 5);
    fault = 1'b0;
    tick();
    check_eq("fault_hold_en", state_o, 5);
    en = 1'b0;
    tick();
    check_eq("fault_exit_idle", state_o, 0);
    check_eq("fault_lat_clear", fault_lat, 0);
    en = 1'b1;
    tick();
    check_eq("fault_reenter_ls", state_o, 1);

`ifdef STEPDOWN_SEQ_ZCD_EN
    gif.pwm_req = 1'b0;
    minon_cfg = 6'd0;
    goto_ls();
    gif.zcd = 1'b1;
    tick();
    check_eq("zcd_ls_off", gif.ls_on, 0);
    check_eq("zcd_park", state_o, 6);
    gif.pwm_req = 1'b1;
    tick();
    check_eq("zcd_hs_direct", gif.hs_on, 1);
    gif.zcd = 1'b0;
`endif

    // Asynchronous reset while HS conducts.
    minon_cfg = 6'd30;
    gif.pwm_req = 1'b1;
    for (int i = 0; i < 20 && !gif.hs_on; i++) tick();
    check_eq("pre_rst_hs", gif.hs_on, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_hs", gif.hs_on, 0);
    check_eq("async_rst_state", state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomised run against the reference.
    run = 0;
    for (int i = 0; i < 2500; i++) begin
      if (run == 0) begin
        gif.pwm_req = 1'($urandom);
        run = $urandom_range(1, 12);
      end
      run--;
      en = ($urandom_range(0, 99) < 95);
      fault = ($urandom_range(0, 99) < 2);
      gif.zcd = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 9) == 0) dt_cfg = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) minon_cfg = 6'($urandom_range(0, 12));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
